// File: rtl/cpu_control_if.sv
// Control bus between cpu_control and its neighbours: instruction/handshake
// inputs plus every datapath control line and the sign-extended immediates.
interface cpu_control_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [1:0]  vsel;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;

  modport master (
    output in, load, s,
    input  w, sximm8, sximm5, vsel, writenum, readnum, write,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop
  );

  modport slave (
    input  in, load, s,
    output w, sximm8, sximm5, vsel, writenum, readnum, write,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop
  );
endinterface

// File: rtl/cpu_control.sv
// Instruction register, decoder and multi-cycle control FSM driving the datapath.
// One instruction per start pulse; all control outputs are Moore (state + IR).
module cpu_control (
  input  logic          clk,
  input  logic          reset,
  cpu_control_if.slave  bus
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  logic is_mov_imm;
  logic is_mov_reg;
  logic is_add;
  logic is_cmp;
  logic is_and;
  logic is_mvn;

  always_comb begin
    is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    is_add     = (opcode == 3'b101) && (op == 2'b00);
    is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    is_and     = (opcode == 3'b101) && (op == 2'b10);
    is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR only changes while idle, so a running instruction is never disturbed.
  always_comb begin
    ir_d = ir_q;
    if ((state_q == S_WAIT) && bus.load) begin
      ir_d = bus.in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (bus.s) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov_imm) begin
          state_d = S_WRITE_IMM;
        end else if (is_mov_reg || is_mvn) begin
          state_d = S_GET_B;
        end else if (is_add || is_cmp || is_and) begin
          state_d = S_GET_A;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  logic       w_o;
  logic [1:0] vsel_o;
  logic [2:0] writenum_o;
  logic [2:0] readnum_o;
  logic       write_o;
  logic       loada_o;
  logic       loadb_o;
  logic       loadc_o;
  logic       loads_o;
  logic       asel_o;
  logic       bsel_o;
  logic [1:0] shift_o;
  logic [1:0] alu_op_o;

  always_comb begin
    w_o        = 1'b0;
    vsel_o     = 2'b00;
    writenum_o = 3'd0;
    readnum_o  = 3'd0;
    write_o    = 1'b0;
    loada_o    = 1'b0;
    loadb_o    = 1'b0;
    loadc_o    = 1'b0;
    loads_o    = 1'b0;
    asel_o     = 1'b0;
    bsel_o     = 1'b0;
    shift_o    = 2'b00;
    alu_op_o   = 2'b00;
    case (state_q)
      S_WAIT: begin
        w_o = 1'b1;
      end
      S_WRITE_IMM: begin
        vsel_o     = 2'b01;
        writenum_o = rn;
        write_o    = 1'b1;
      end
      S_GET_A: begin
        readnum_o = rn;
        loada_o   = 1'b1;
      end
      S_GET_B: begin
        readnum_o = rm;
        loadb_o   = 1'b1;
      end
      S_ALU: begin
        // MOV reg and MVN take only the B operand, so A is forced to zero.
        shift_o  = sh;
        bsel_o   = 1'b0;
        alu_op_o = is_mov_reg ? 2'b00 : op;
        asel_o   = is_mov_reg || is_mvn;
        loadc_o  = !is_cmp;
        loads_o  = is_cmp;
      end
      S_WRITE_REG: begin
        vsel_o     = 2'b11;
        writenum_o = rd;
        write_o    = 1'b1;
      end
      default: begin
        w_o = 1'b0;
      end
    endcase
  end

  assign bus.w        = w_o;
  assign bus.vsel     = vsel_o;
  assign bus.writenum = writenum_o;
  assign bus.readnum  = readnum_o;
  assign bus.write    = write_o;
  assign bus.loada    = loada_o;
  assign bus.loadb    = loadb_o;
  assign bus.loadc    = loadc_o;
  assign bus.loads    = loads_o;
  assign bus.asel     = asel_o;
  assign bus.bsel     = bsel_o;
  assign bus.shift    = shift_o;
  assign bus.ALUop    = alu_op_o;
  assign bus.sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
  assign bus.sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: per-cycle control vectors are hand-derived
// for each instruction and compared on the falling clock edge.
module tb_cpu_control;

  logic clk;
  logic reset;

  cpu_control_if bus ();

  cpu_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Flag field order: write, loada, loadb, loadc, loads, asel, bsel
  localparam logic [6:0] F_NONE  = 7'b0000000;
  localparam logic [6:0] F_WRITE = 7'b1000000;
  localparam logic [6:0] F_LOADA = 7'b0100000;
  localparam logic [6:0] F_LOADB = 7'b0010000;
  localparam logic [6:0] F_LOADC = 7'b0001000;
  localparam logic [6:0] F_LOADS = 7'b0000100;
  localparam logic [6:0] F_ASEL  = 7'b0000010;

  logic [19:0] obs;
  assign obs = {bus.w, bus.vsel, bus.writenum, bus.readnum,
                bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads,
                bus.asel, bus.bsel, bus.shift, bus.ALUop};

  function automatic logic [19:0] ctl(input logic w, input logic [1:0] vsel,
                                      input logic [2:0] wn, input logic [2:0] rn,
                                      input logic [6:0] flags,
                                      input logic [1:0] sh, input logic [1:0] alu);
    return {w, vsel, wn, rn, flags, sh, alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step(input string tag, input logic [19:0] exp);
    @(negedge clk);
    check(tag, {12'd0, obs}, {12'd0, exp});
  endtask

  // Load and start together; the FSM must execute the freshly loaded word.
  task automatic issue(input string tag, input logic [15:0] word);
    bus.in   = word;
    bus.load = 1'b1;
    bus.s    = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bus.s    = 1'b0;
    check({tag, "_decode"}, {12'd0, obs}, 32'd0);
  endtask

  localparam logic [19:0] C_WAIT = 20'h80000;
  localparam logic [19:0] C_BUSY = 20'h00000;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.in   = 16'h0000;
    bus.load = 1'b0;
    bus.s    = 1'b0;

    #7;
    check("rst_ctl", {12'd0, obs}, {12'd0, C_WAIT});
    check("rst_sximm8", {16'd0, bus.sximm8}, 32'h0);
    check("rst_sximm5", {16'd0, bus.sximm5}, 32'h0);

    @(negedge clk);
    reset = 1'b0;

    // MOV R0,#7: load alone must not start anything
    bus.in   = 16'hD007;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    check("ld_idle", {12'd0, obs}, {12'd0, C_WAIT});
    check("d007_sximm8", {16'd0, bus.sximm8}, 32'h0007);
    check("d007_sximm5", {16'd0, bus.sximm5}, 32'h0007);
    bus.s = 1'b1;
    @(negedge clk);
    bus.s = 1'b0;
    check("movi0_decode", {12'd0, obs}, {12'd0, C_BUSY});
    step("movi0_write", ctl(1'b0, 2'b01, 3'd0, 3'd0, F_WRITE, 2'b00, 2'b00));
    step("movi0_done", C_WAIT);

    // MOV R1,#2
    issue("movi1", 16'hD102);
    step("movi1_write", ctl(1'b0, 2'b01, 3'd1, 3'd0, F_WRITE, 2'b00, 2'b00));
    step("movi1_done", C_WAIT);

    // ADD R2,R1,R0,LSL#1 with a load of 0xD105 attempted while it runs
    issue("add", 16'hA148);
    bus.in   = 16'hD105;
    bus.load = 1'b1;
    step("add_get_a", ctl(1'b0, 2'b00, 3'd0, 3'd1, F_LOADA, 2'b00, 2'b00));
    step("add_get_b", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADB, 2'b00, 2'b00));
    step("add_alu", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADC, 2'b01, 2'b00));
    step("add_write", ctl(1'b0, 2'b11, 3'd2, 3'd0, F_WRITE, 2'b00, 2'b00));
    bus.load = 1'b0;
    check("add_ir_kept", {16'd0, bus.sximm8}, 32'h0048);
    step("add_done", C_WAIT);
    check("add_sximm5", {16'd0, bus.sximm5}, 32'h0008);

    // CMP R0,R0 with s held high: restart is taken one edge after WAIT
    bus.in   = 16'hA800;
    bus.load = 1'b1;
    bus.s    = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    check("cmp_decode", {12'd0, obs}, {12'd0, C_BUSY});
    step("cmp_get_a", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADA, 2'b00, 2'b00));
    step("cmp_get_b", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADB, 2'b00, 2'b00));
    step("cmp_alu", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADS, 2'b00, 2'b01));
    step("cmp_wait_s_high", C_WAIT);
    step("cmp2_decode", C_BUSY);
    bus.s = 1'b0;
    step("cmp2_get_a", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADA, 2'b00, 2'b00));
    step("cmp2_get_b", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADB, 2'b00, 2'b00));
    step("cmp2_alu", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADS, 2'b00, 2'b01));
    step("cmp2_done", C_WAIT);

    // MVN R3,R0
    issue("mvn", 16'hB860);
    step("mvn_get_b", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADB, 2'b00, 2'b00));
    step("mvn_alu", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADC | F_ASEL, 2'b00, 2'b11));
    step("mvn_write", ctl(1'b0, 2'b11, 3'd3, 3'd0, F_WRITE, 2'b00, 2'b00));
    step("mvn_done", C_WAIT);

    // MOV R5,R1,LSR#1 (0xC0B1): negative immediates exercise sign extension
    issue("movr", 16'hC0B1);
    check("c0b1_sximm8", {16'd0, bus.sximm8}, 32'hFFB1);
    check("c0b1_sximm5", {16'd0, bus.sximm5}, 32'hFFF1);
    step("movr_get_b", ctl(1'b0, 2'b00, 3'd0, 3'd1, F_LOADB, 2'b00, 2'b00));
    step("movr_alu", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADC | F_ASEL, 2'b10, 2'b00));
    step("movr_write", ctl(1'b0, 2'b11, 3'd5, 3'd0, F_WRITE, 2'b00, 2'b00));
    step("movr_done", C_WAIT);

    // Undefined encodings: one busy cycle, no side effects
    issue("undef_e000", 16'hE000);
    step("undef_e000_done", C_WAIT);
    issue("undef_c800", 16'hC800);
    step("undef_c800_done", C_WAIT);

    // Reset in GET_B takes effect without a clock edge
    issue("add_rst", 16'hA148);
    step("add_rst_get_a", ctl(1'b0, 2'b00, 3'd0, 3'd1, F_LOADA, 2'b00, 2'b00));
    step("add_rst_get_b", ctl(1'b0, 2'b00, 3'd0, 3'd0, F_LOADB, 2'b00, 2'b00));
    reset = 1'b1;
    #1;
    check("async_rst_ctl", {12'd0, obs}, {12'd0, C_WAIT});
    check("async_rst_ir", {16'd0, bus.sximm8}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst_idle", C_WAIT);
    check("post_rst_sximm5", {16'd0, bus.sximm5}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
